// File: rtl/end_screen_pkg.sv
// end_screen_pkg: shared types and constants for the end-screen animator.
//   - state_e   : animator FSM states
//   - TILE_*    : default tile codes for blank, win-face and lose-face cells
//   - WIN_MASK  : 12x17 smile pattern, LOSE_MASK : 12x17 frown pattern
// Mask layout: MASK[r][c], row 0 is the top row; a set bit draws the face tile.
package end_screen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReveal,
    StBlink,
    StWaitPress
  } state_e;

  localparam int unsigned MASK_ROWS = 12;
  localparam int unsigned MASK_COLS = 17;

  localparam logic [7:0] TILE_BDR = 8'd0;
  localparam logic [7:0] TILE_SKY = 8'd1;
  localparam logic [7:0] TILE_BLK = 8'd2;

  // Listed bottom row (11) first so the packed index matches the row number.
  localparam logic [MASK_ROWS-1:0][MASK_COLS-1:0] WIN_MASK = {
    17'b00000111111100000,  // row 11
    17'b00011000000011000,  // row 10
    17'b00100011111000100,  // row 9
    17'b01000100000100010,  // row 8
    17'b01001000000010010,  // row 7
    17'b01000000000000010,  // row 6
    17'b01000000000000010,  // row 5
    17'b01000110001100010,  // row 4
    17'b01000110001100010,  // row 3
    17'b00100000000000100,  // row 2
    17'b00011000000011000,  // row 1
    17'b00000111111100000   // row 0
  };

  localparam logic [MASK_ROWS-1:0][MASK_COLS-1:0] LOSE_MASK = {
    17'b00000111111100000,  // row 11
    17'b00011000000011000,  // row 10
    17'b00101000000010100,  // row 9
    17'b01000100000100010,  // row 8
    17'b01000011111000010,  // row 7
    17'b01000000000000010,  // row 6
    17'b01000000000000010,  // row 5
    17'b01000110001100010,  // row 4
    17'b01000110001100010,  // row 3
    17'b00100000000000100,  // row 2
    17'b00011000000011000,  // row 1
    17'b00000111111100000   // row 0
  };

endpackage

// File: rtl/anim_tick_gen.sv
// anim_tick_gen: prescaler producing a one-cycle tick every TICK_CYCLES enabled cycles.
// Ports:
//   i_clk     clock
//   i_reset   synchronous active-high reset
//   i_clear   synchronous clear of the prescaler (restarts the period)
//   i_enable  counter advances only while high
//   o_tick    one-cycle pulse on the wrap from TICK_CYCLES-1 to 0
module anim_tick_gen #(
  parameter int unsigned TICK_CYCLES = 416667
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_CYCLES - 1);

  logic [CntW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == CntLast);
  assign o_tick = i_enable && w_wrap && !i_clear;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/end_screen_animator.sv
// end_screen_animator: animated win/lose face on the tile background.
// Reveals the face row by row, blinks it, then holds until a fresh jump press,
// which produces a one-cycle restart pulse.
// Ports:
//   i_vga_clock    sole clock
//   i_reset        synchronous active-high reset
//   i_start        one-cycle request to begin (ignored while busy)
//   i_mode         0 = win face, 1 = lose face; latched on accepted start
//   i_jump_button  synchronised jump level
//   o_background   registered ROWS x COLS tile map (8-bit tile codes)
//   o_mario_*/o_goomba_*  sprite coordinates, constant OFFSCREEN
//   o_seconds      whole seconds since start, saturating at 999
//   o_busy         high in every state except idle
//   o_restart      one-cycle pulse on an acknowledged jump press
// Build option: END_SCREEN_SKIP_EN lets a jump press during reveal/blink jump
// straight to the held full face (that press does not restart).
// ROWS/COLS must not exceed the package mask dimensions.
module end_screen_animator
  import end_screen_pkg::*;
#(
  parameter logic [7:0]  BDR              = TILE_BDR,
  parameter logic [7:0]  SKY              = TILE_SKY,
  parameter logic [7:0]  BLK              = TILE_BLK,
  parameter int unsigned ROWS             = MASK_ROWS,
  parameter int unsigned COLS             = MASK_COLS,
  parameter int unsigned TICK_CYCLES      = 416667,
  parameter int unsigned REVEAL_TICKS     = 6,
  parameter int unsigned BLINK_TICKS      = 15,
  parameter int unsigned BLINKS           = 3,
  parameter int unsigned TICKS_PER_SECOND = 60,
  parameter int          OFFSCREEN        = 1000
) (
  input  logic                          i_vga_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_mode,
  input  logic                          i_jump_button,
  output logic [ROWS-1:0][COLS-1:0][7:0] o_background,
  output logic [31:0]                   o_mario_x,
  output logic [31:0]                   o_mario_y,
  output logic [31:0]                   o_goomba_x,
  output logic [31:0]                   o_goomba_y,
  output logic [31:0]                   o_seconds,
  output logic                          o_busy,
  output logic                          o_restart
);

  localparam int unsigned RowW     = $clog2(ROWS + 1);
  localparam int unsigned SubMax   = (REVEAL_TICKS > BLINK_TICKS) ? REVEAL_TICKS : BLINK_TICKS;
  localparam int unsigned SubW     = (SubMax > 1) ? $clog2(SubMax) : 1;
  localparam int unsigned BlinkW   = $clog2(BLINKS + 1);
  localparam int unsigned SecTickW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam logic [9:0]  SecMax   = 10'd999;

`ifdef END_SCREEN_SKIP_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  state_e                         r_state, w_state_next;
  logic [RowW-1:0]                r_row_cnt, w_row_cnt_next;
  logic [SubW-1:0]                r_sub_cnt, w_sub_cnt_next;
  logic [BlinkW-1:0]              r_blink_cnt, w_blink_cnt_next;
  logic                           r_phase_on, w_phase_on_next;
  logic                           r_mode, w_mode_next;
  logic                           r_restart, w_restart_next;
  logic                           r_jump_q;
  logic [SecTickW-1:0]            r_sec_tick, w_sec_tick_next;
  logic [9:0]                     r_seconds, w_seconds_next;
  logic [ROWS-1:0][COLS-1:0][7:0] r_background, w_background_next;
  logic [ROWS-1:0]                w_row_vis;
  logic [MASK_ROWS-1:0][MASK_COLS-1:0] w_mask;
  logic [7:0]                     w_face;
  logic                           w_tick, w_busy, w_start_acc, w_jump_rise;

  assign w_busy      = (r_state != StIdle);
  assign w_start_acc = i_start && (r_state == StIdle);
  assign w_jump_rise = i_jump_button && !r_jump_q;

  anim_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .i_clk   (i_vga_clock),
    .i_reset (i_reset),
    .i_clear (w_start_acc),
    .i_enable(w_busy),
    .o_tick  (w_tick)
  );

  // Next-state and counter logic.
  always_comb begin
    w_state_next     = r_state;
    w_row_cnt_next   = r_row_cnt;
    w_sub_cnt_next   = r_sub_cnt;
    w_blink_cnt_next = r_blink_cnt;
    w_phase_on_next  = r_phase_on;
    w_mode_next      = r_mode;
    w_restart_next   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_mode_next    = i_mode;
          w_row_cnt_next = '0;
          w_sub_cnt_next = '0;
          w_state_next   = StReveal;
        end
      end
      StReveal: begin
        if (SkipEn && w_jump_rise) begin
          w_state_next = StWaitPress;
        end else if (r_row_cnt == RowW'(ROWS)) begin
          // Full face has been on screen for one cycle; start blinking dark.
          w_state_next     = StBlink;
          w_sub_cnt_next   = '0;
          w_blink_cnt_next = '0;
          w_phase_on_next  = 1'b0;
        end else if (w_tick) begin
          if (r_sub_cnt == SubW'(REVEAL_TICKS - 1)) begin
            w_sub_cnt_next = '0;
            w_row_cnt_next = r_row_cnt + RowW'(1);
          end else begin
            w_sub_cnt_next = r_sub_cnt + SubW'(1);
          end
        end
      end
      StBlink: begin
        if (SkipEn && w_jump_rise) begin
          w_state_next = StWaitPress;
        end else if (w_tick) begin
          if (r_sub_cnt == SubW'(BLINK_TICKS - 1)) begin
            w_sub_cnt_next  = '0;
            w_phase_on_next = !r_phase_on;
            if (!r_phase_on) begin
              w_blink_cnt_next = r_blink_cnt + BlinkW'(1);
              // Last off->on toggle: hold the face from here on.
              if (r_blink_cnt == BlinkW'(BLINKS - 1)) w_state_next = StWaitPress;
            end
          end else begin
            w_sub_cnt_next = r_sub_cnt + SubW'(1);
          end
        end
      end
      StWaitPress: begin
        if (w_jump_rise) begin
          w_restart_next = 1'b1;
          w_state_next   = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Seconds: ticks only arrive while busy, so the count freezes in idle.
  always_comb begin
    w_seconds_next  = r_seconds;
    w_sec_tick_next = r_sec_tick;
    if (w_start_acc) begin
      w_seconds_next  = '0;
      w_sec_tick_next = '0;
    end else if (w_tick) begin
      if (r_sec_tick == SecTickW'(TICKS_PER_SECOND - 1)) begin
        w_sec_tick_next = '0;
        if (r_seconds != SecMax) w_seconds_next = r_seconds + 10'd1;
      end else begin
        w_sec_tick_next = r_sec_tick + SecTickW'(1);
      end
    end
  end

  // Tile map from the current state and counters; registered below.
  assign w_mask = r_mode ? LOSE_MASK : WIN_MASK;
  assign w_face = r_mode ? BLK : SKY;

  always_comb begin
    w_row_vis         = '0;
    w_background_next = {(ROWS * COLS){BDR}};
    for (int r = 0; r < ROWS; r++) begin
      case (r_state)
        StReveal:    w_row_vis[r] = (RowW'(r) < r_row_cnt);
        StBlink:     w_row_vis[r] = r_phase_on;
        StWaitPress: w_row_vis[r] = 1'b1;
        default:     w_row_vis[r] = 1'b0;
      endcase
      for (int c = 0; c < COLS; c++) begin
        if (w_row_vis[r] && w_mask[r][c]) w_background_next[r][c] = w_face;
      end
    end
  end

  always_ff @(posedge i_vga_clock) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_row_cnt    <= '0;
      r_sub_cnt    <= '0;
      r_blink_cnt  <= '0;
      r_phase_on   <= 1'b0;
      r_mode       <= 1'b0;
      r_restart    <= 1'b0;
      r_jump_q     <= 1'b0;
      r_sec_tick   <= '0;
      r_seconds    <= '0;
      r_background <= {(ROWS * COLS){BDR}};
    end else begin
      r_state      <= w_state_next;
      r_row_cnt    <= w_row_cnt_next;
      r_sub_cnt    <= w_sub_cnt_next;
      r_blink_cnt  <= w_blink_cnt_next;
      r_phase_on   <= w_phase_on_next;
      r_mode       <= w_mode_next;
      r_restart    <= w_restart_next;
      r_jump_q     <= i_jump_button;
      r_sec_tick   <= w_sec_tick_next;
      r_seconds    <= w_seconds_next;
      r_background <= w_background_next;
    end
  end

  assign o_background = r_background;
  assign o_seconds    = {22'd0, r_seconds};
  assign o_busy       = w_busy;
  assign o_restart    = r_restart;
  assign o_mario_x    = OFFSCREEN;
  assign o_mario_y    = OFFSCREEN;
  assign o_goomba_x   = OFFSCREEN;
  assign o_goomba_y   = OFFSCREEN;

endmodule
